wb_regfile: RTL and testbench

Write-back stage and architectural register file of the five-stage pipeline. It consumes the MEM/WB pipeline register outputs, selects the write-back data and destination register, and commits the result to a 32×32-bit register file. It serves the two ID-stage read ports with same-cycle write-through bypass and exports the committed write for the forwarding unit. It also keeps a running count of committed register writes.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/regfile_2r1w.sv | 42 ++++
 rtl/wb_regfile.sv | 85 ++++++++
 tb/tb_wb_regfile.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings and register indices for the pipeline.
// Holds the write-back select codes and the fixed architectural register numbers.
package cpu_pkg;

  typedef enum logic [1:0] {
    REGDST_RD = 2'b00,
    REGDST_RT = 2'b01,
    REGDST_RA = 2'b10,
    REGDST_XP = 2'b11
  } regdst_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_PC  = 2'b11
  } memtoreg_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file with two combinational read ports and one write port.
// Reads that hit the in-flight write return the write data.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  logic [31:0] r_regs [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= (i == int'(REG_SP)) ? SP_INIT : 32'd0;
      end
    end else if (i_we && (i_waddr != REG_ZERO)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Register 0 stays zero even if a bypass targets it.
  always_comb begin
    o_rdata1 = r_regs[i_raddr1];
    if (i_we && (i_raddr1 == i_waddr)) o_rdata1 = i_wdata;
    if (i_raddr1 == REG_ZERO) o_rdata1 = 32'd0;

    o_rdata2 = r_regs[i_raddr2];
    if (i_we && (i_raddr2 == i_waddr)) o_rdata2 = i_wdata;
    if (i_raddr2 == REG_ZERO) o_rdata2 = 32'd0;
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects destination and data, commits to the register file,
// exports the committed write for forwarding and counts committed writes.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h0000_0400,
  parameter logic [4:0]  XP_REG  = 5'd26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_plus4,
  input  logic [31:0] Data_Mem_Out,
  input  logic [31:0] ALUOut,
  input  logic [1:0]  RegDst,
  input  logic        RegWr,
  input  logic [1:0]  MemToReg,
  input  logic [4:0]  RegisterRd,
  input  logic [4:0]  RegisterRt,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] wb_count
);

  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        w_we;
  logic [31:0] r_wb_count;

  always_comb begin
    w_addr = RegisterRd;
    unique case (regdst_e'(RegDst))
      REGDST_RD: w_addr = RegisterRd;
      REGDST_RT: w_addr = RegisterRt;
      REGDST_RA: w_addr = REG_RA;
      REGDST_XP: w_addr = XP_REG;
      default:   w_addr = RegisterRd;
    endcase
  end

  always_comb begin
    w_data = ALUOut;
    unique case (memtoreg_e'(MemToReg))
      WB_ALU:  w_data = ALUOut;
      WB_MEM:  w_data = Data_Mem_Out;
      WB_PC4:  w_data = PC_plus4;
      WB_PC:   w_data = PC_plus4 - 32'd4;
      default: w_data = ALUOut;
    endcase
  end

  assign w_we = RegWr && (w_addr != REG_ZERO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_count <= 32'd0;
    end else if (w_we) begin
      r_wb_count <= r_wb_count + 32'd1;
    end
  end

  regfile_2r1w #(
    .SP_INIT (SP_INIT)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_we     (w_we),
    .i_waddr  (w_addr),
    .i_wdata  (w_data),
    .i_raddr1 (rs_addr),
    .i_raddr2 (rt_addr),
    .o_rdata1 (rs_data),
    .o_rdata2 (rt_data)
  );

  assign wb_we    = w_we;
  assign wb_addr  = w_addr;
  assign wb_data  = w_data;
  assign wb_count = r_wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic [31:0] PC_plus4;
  logic [31:0] Data_Mem_Out;
  logic [31:0] ALUOut;
  logic [1:0]  RegDst;
  logic        RegWr;
  logic [1:0]  MemToReg;
  logic [4:0]  RegisterRd;
  logic [4:0]  RegisterRt;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_count;

  int n_pass;
  int n_chk;

  wb_regfile #(
    .SP_INIT (32'h0000_0400),
    .XP_REG  (5'd26)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .PC_plus4     (PC_plus4),
    .Data_Mem_Out (Data_Mem_Out),
    .ALUOut       (ALUOut),
    .RegDst       (RegDst),
    .RegWr        (RegWr),
    .MemToReg     (MemToReg),
    .RegisterRd   (RegisterRd),
    .RegisterRt   (RegisterRt),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_count     (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Advance through one rising edge and return to the low phase.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_pass       = 0;
    n_chk        = 0;
    reset        = 1'b1;
    PC_plus4     = '0;
    Data_Mem_Out = '0;
    ALUOut       = '0;
    RegDst       = 2'b00;
    RegWr        = 1'b0;
    MemToReg     = 2'b00;
    RegisterRd   = '0;
    RegisterRt   = '0;
    rs_addr      = 5'd0;
    rt_addr      = 5'd29;

    @(negedge clk);
    #1;
    check_eq("rst_r0", rs_data, 32'h0);
    check_eq("rst_sp", rt_data, 32'h0000_0400);
    check_eq("rst_cnt", wb_count, 32'h0);
    rs_addr = 5'd5;
    #1;
    check_eq("rst_r5", rs_data, 32'h0);
    reset = 1'b0;
    step();
    check_eq("post_rst_sp", rt_data, 32'h0000_0400);

    // ALU result to Rd with same-cycle read
    RegWr = 1'b1; RegDst = 2'b00; RegisterRd = 5'd8; MemToReg = 2'b00;
    ALUOut = 32'hDEAD_BEEF; rs_addr = 5'd8;
    #1;
    check_eq("byp_r8", rs_data, 32'hDEAD_BEEF);
    check_eq("we_r8", {31'd0, wb_we}, 32'd1);
    check_eq("addr_r8", {27'd0, wb_addr}, 32'd8);
    step();
    RegWr = 1'b0;
    #1;
    check_eq("stored_r8", rs_data, 32'hDEAD_BEEF);
    check_eq("cnt1", wb_count, 32'd1);

    // Link register and exception register paths
    RegWr = 1'b1; RegDst = 2'b10; MemToReg = 2'b10; PC_plus4 = 32'h0040_0010;
    #1;
    check_eq("addr_ra", {27'd0, wb_addr}, 32'd31);
    check_eq("data_pc4", wb_data, 32'h0040_0010);
    step();
    RegDst = 2'b11; MemToReg = 2'b11; rs_addr = 5'd31; rt_addr = 5'd26;
    #1;
    check_eq("addr_xp", {27'd0, wb_addr}, 32'd26);
    check_eq("data_pc", wb_data, 32'h0040_000C);
    check_eq("stored_ra", rs_data, 32'h0040_0010);
    check_eq("byp_xp", rt_data, 32'h0040_000C);
    step();
    RegWr = 1'b0;
    #1;
    check_eq("stored_xp", rt_data, 32'h0040_000C);
    check_eq("cnt3", wb_count, 32'd3);

    // Write to register 0 is suppressed
    RegWr = 1'b1; RegDst = 2'b01; RegisterRt = 5'd0; MemToReg = 2'b01;
    Data_Mem_Out = 32'h1234_5678; rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    check_eq("r0_rs", rs_data, 32'h0);
    check_eq("r0_rt", rt_data, 32'h0);
    check_eq("r0_we", {31'd0, wb_we}, 32'd0);
    check_eq("data_mem", wb_data, 32'h1234_5678);
    step();
    check_eq("r0_cnt", wb_count, 32'd3);

    // Both ports hit the bypass
    RegDst = 2'b00; RegisterRd = 5'd12; MemToReg = 2'b00; ALUOut = 32'hCAFE_F00D;
    rs_addr = 5'd12; rt_addr = 5'd12;
    #1;
    check_eq("dual_rs", rs_data, 32'hCAFE_F00D);
    check_eq("dual_rt", rt_data, 32'hCAFE_F00D);
    step();
    RegWr = 1'b0;
    check_eq("cnt4", wb_count, 32'd4);

    // PC_plus4 - 4 wraps
    PC_plus4 = 32'h0; MemToReg = 2'b11;
    #1;
    check_eq("pc_wrap", wb_data, 32'hFFFF_FFFC);
    check_eq("we_off", {31'd0, wb_we}, 32'd0);

    // Counter wrap from all-ones
    force dut.r_wb_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_wb_count;
    #1;
    check_eq("cnt_max", wb_count, 32'hFFFF_FFFF);
    RegWr = 1'b1; RegisterRd = 5'd13; MemToReg = 2'b00; ALUOut = 32'h1;
    step();
    RegWr = 1'b0;
    #1;
    check_eq("cnt_wrap", wb_count, 32'h0);

    // Asynchronous reset between edges
    RegWr = 1'b1; RegisterRd = 5'd9; ALUOut = 32'h0000_0099;
    step();
    RegWr = 1'b0; rs_addr = 5'd9; rt_addr = 5'd29;
    #1;
    check_eq("r9_pre", rs_data, 32'h0000_0099);
    check_eq("cnt_pre", wb_count, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("arst_r9", rs_data, 32'h0);
    check_eq("arst_cnt", wb_count, 32'h0);
    check_eq("arst_sp", rt_data, 32'h0000_0400);

    // No write on edges while reset is held
    RegWr = 1'b1; RegisterRd = 5'd9; ALUOut = 32'h5555_AAAA; rs_addr = 5'd10;
    step();
    RegWr = 1'b0; rs_addr = 5'd9;
    reset = 1'b0;
    #1;
    check_eq("held_r9", rs_data, 32'h0);
    check_eq("held_cnt", wb_count, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
